// File: rtl/bit_unstuffer.sv
// Receive-side USB bit unstuffer: forwards decoded bits, strips the stuffed 0
// after MAX_ONES consecutive 1s and flags a seventh 1 as a stuffing error.
module bit_unstuffer #(
    parameter int PID_BITS = 8,
    parameter int MAX_ONES = 6
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rx_start,
    input  logic in_valid,
    input  logic in_bit,
    input  logic rx_eop,
    output logic out_bit,
    output logic out_valid,
    output logic drop_pulse,
    output logic stuff_err,
    output logic rx_active
);

    localparam int CW = (PID_BITS > 1) ? $clog2(PID_BITS) : 1;
    localparam int OW = $clog2(MAX_ONES + 1);
    localparam logic [CW-1:0] PID_LAST  = CW'(PID_BITS - 1);
    localparam logic [OW-1:0] ONES_LAST = OW'(MAX_ONES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_STRIP,
        ST_ERROR
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [OW-1:0]   ones_cnt_reg, ones_cnt_next;
    logic            out_bit_next, out_valid_next, drop_pulse_next, stuff_err_next;
    logic            rx_active_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
            out_bit      <= 1'b0;
            out_valid    <= 1'b0;
            drop_pulse   <= 1'b0;
            stuff_err    <= 1'b0;
            rx_active    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            ones_cnt_reg <= ones_cnt_next;
            out_bit      <= out_bit_next;
            out_valid    <= out_valid_next;
            drop_pulse   <= drop_pulse_next;
            stuff_err    <= stuff_err_next;
            rx_active    <= rx_active_next;
        end
    end

    // EOP wins over a coincident valid bit; idle strobes hold everything.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        ones_cnt_next = ones_cnt_reg;
        if (rx_eop) begin
            state_next    = ST_IDLE;
            bit_cnt_next  = '0;
            ones_cnt_next = '0;
        end else if (in_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (rx_start) begin
                        state_next    = ST_PID;
                        bit_cnt_next  = CW'(1);
                        ones_cnt_next = '0;
                    end
                end
                ST_PID: begin
                    if (bit_cnt_reg == PID_LAST) begin
                        // Last PID bit seeds the run of ones.
                        state_next    = ST_DATA;
                        bit_cnt_next  = '0;
                        ones_cnt_next = OW'(in_bit);
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (!in_bit) begin
                        ones_cnt_next = '0;
                    end else if (ones_cnt_reg == ONES_LAST) begin
                        ones_cnt_next = '0;
                        state_next    = ST_STRIP;
                    end else begin
                        ones_cnt_next = ones_cnt_reg + OW'(1);
                    end
                end
                ST_STRIP: begin
                    state_next = in_bit ? ST_ERROR : ST_DATA;
                end
                ST_ERROR: begin
                    state_next = ST_ERROR;
                end
                default: begin
                    state_next    = ST_IDLE;
                    bit_cnt_next  = '0;
                    ones_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid_next  = 1'b0;
        drop_pulse_next = 1'b0;
        stuff_err_next  = 1'b0;
        if (!rx_eop && in_valid) begin
            case (state_reg)
                ST_IDLE:  out_valid_next  = rx_start;
                ST_PID,
                ST_DATA:  out_valid_next  = 1'b1;
                ST_STRIP: begin
                    drop_pulse_next = !in_bit;
                    stuff_err_next  = in_bit;
                end
                default:  out_valid_next  = 1'b0;
            endcase
        end
        out_bit_next   = out_valid_next ? in_bit : out_bit;
        rx_active_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_bit_unstuffer.sv
// Self-checking bench for bit_unstuffer: directed tables, hand-written corner
// sequences and random packets checked cycle by cycle against a packet-level model.
module tb_bit_unstuffer;

    localparam int PID_BITS = 8;
    localparam int MAX_ONES = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic rx_start = 1'b0, in_valid = 1'b0, in_bit = 1'b0, rx_eop = 1'b0;
    logic out_bit, out_valid, drop_pulse, stuff_err, rx_active;

    bit_unstuffer #(.PID_BITS(PID_BITS), .MAX_ONES(MAX_ONES)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_start   (rx_start),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .rx_eop     (rx_eop),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .drop_pulse (drop_pulse),
        .stuff_err  (stuff_err),
        .rx_active  (rx_active)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Packet-level reference: position in packet, run of counted ones,
    // whether the next bit must be a stuff bit, whether the packet is dead.
    bit m_active, m_dead, m_pend, m_ob;
    int m_pos, m_run;

    logic fwd_q[$];
    int   drop_cnt, err_cnt;

    typedef struct {
        logic s, v, b, e;
        logic ov, ob, drop, err, act;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_dead = 0; m_pend = 0; m_ob = 0; m_pos = 0; m_run = 0;
    endtask

    task automatic cycle(input logic s, input logic v, input logic b, input logic e);
        logic eov, edrop, eerr;
        rx_start = s; in_valid = v; in_bit = b; rx_eop = e;
        eov = 0; edrop = 0; eerr = 0;
        if (e) begin
            model_reset_keep_ob();
        end else if (v) begin
            if (!m_active) begin
                if (s) begin
                    eov = 1; m_active = 1; m_pos = 1; m_run = 0;
                end
            end else if (m_dead) begin
                eov = 0;
            end else if (m_pend) begin
                m_pend = 0;
                if (b) begin
                    eerr = 1; m_dead = 1;
                end else begin
                    edrop = 1;
                end
            end else begin
                eov = 1;
                if (m_pos >= PID_BITS - 1) begin
                    m_run = b ? m_run + 1 : 0;
                    if (m_run == MAX_ONES) begin
                        m_pend = 1; m_run = 0;
                    end
                end
                m_pos++;
            end
        end
        if (eov) m_ob = b;
        @(posedge clock);
        #1;
        chk("out_valid", 32'(out_valid), 32'(eov));
        chk("out_bit", 32'(out_bit), 32'(m_ob));
        chk("drop_pulse", 32'(drop_pulse), 32'(edrop));
        chk("stuff_err", 32'(stuff_err), 32'(eerr));
        chk("rx_active", 32'(rx_active), 32'(m_active));
        if (out_valid) fwd_q.push_back(out_bit);
        if (drop_pulse) drop_cnt++;
        if (stuff_err) err_cnt++;
    endtask

    task automatic model_reset_keep_ob();
        m_active = 0; m_dead = 0; m_pend = 0; m_pos = 0; m_run = 0;
    endtask

    task automatic clear_log();
        fwd_q.delete(); drop_cnt = 0; err_cnt = 0;
    endtask

    // gap < 0 means a random gap (0..2 idle cycles) after each bit.
    task automatic send(input logic [7:0] pid, input logic [31:0] data, input int n,
                        input int gap);
        int g;
        clear_log();
        for (int i = 0; i < PID_BITS + n; i++) begin
            cycle(i == 0, 1'b1, (i < PID_BITS) ? pid[i] : data[i - PID_BITS], 1'b0);
            g = (gap < 0) ? $urandom_range(0, 2) : gap;
            repeat (g) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic add_vec(input logic s, input logic v, input logic b, input logic e,
                           input logic ov, input logic ob, input logic drop,
                           input logic err, input logic act);
        vec_t r;
        r.s = s; r.v = v; r.b = b; r.e = e;
        r.ov = ov; r.ob = ob; r.drop = drop; r.err = err; r.act = act;
        tbl.push_back(r);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].e);
            chk({name, ".ov"}, 32'(out_valid), 32'(tbl[i].ov));
            chk({name, ".ob"}, 32'(out_bit), 32'(tbl[i].ob));
            chk({name, ".drop"}, 32'(drop_pulse), 32'(tbl[i].drop));
            chk({name, ".err"}, 32'(stuff_err), 32'(tbl[i].err));
            chk({name, ".act"}, 32'(rx_active), 32'(tbl[i].act));
        end
        $display("table %s: %0d vectors, fwd=%0d drops=%0d errs=%0d",
                 name, tbl.size(), fwd_q.size(), drop_cnt, err_cnt);
        tbl.delete();
    endtask

    function automatic logic [31:0] fwd_vec();
        logic [31:0] r = '0;
        for (int i = 0; i < fwd_q.size() && i < 32; i++) r[i] = fwd_q[i];
        return r;
    endfunction

    initial begin
        model_reset();
        clear_log();
        repeat (2) @(posedge clock);
        #1;
        chk("rst.out_bit", 32'(out_bit), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.drop", 32'(drop_pulse), 32'd0);
        chk("rst.err", 32'(stuff_err), 32'd0);
        chk("rst.active", 32'(rx_active), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Valid without start is ignored in IDLE.
        cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Stuff bit removed: PID 0000_0001, data 1,1,1,1,1,1,0,1.
        clear_log();
        add_vec(1, 1, 1, 0, 1, 1, 0, 0, 1);
        for (int i = 1; i < 8; i++) add_vec(0, 1, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) add_vec(0, 1, 1, 0, 1, 1, 0, 0, 1);
        add_vec(0, 1, 0, 0, 0, 1, 1, 0, 1);
        add_vec(0, 1, 1, 0, 1, 1, 0, 0, 1);
        add_vec(0, 0, 0, 1, 0, 1, 0, 0, 0);
        run_table("stuff_strip");

        // Stuff error: seven 1s, then 0,1, then EOP; rx_start ignored in ERROR.
        clear_log();
        add_vec(1, 1, 1, 0, 1, 1, 0, 0, 1);
        for (int i = 1; i < 8; i++) add_vec(0, 1, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) add_vec(0, 1, 1, 0, 1, 1, 0, 0, 1);
        add_vec(0, 1, 1, 0, 0, 1, 0, 1, 1);
        add_vec(1, 1, 0, 0, 0, 1, 0, 0, 1);
        add_vec(0, 1, 1, 0, 0, 1, 0, 0, 1);
        add_vec(0, 0, 0, 1, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_table("stuff_err");

        // PID bit 7 seeds the run: PID 1000_0001, data 1,1,1,1,1,0,0.
        send(8'h81, 32'b0011111, 7, 0);
        chk("seed.drops", 32'(drop_cnt), 32'd1);
        chk("seed.fwd", 32'(fwd_q.size()), 32'd14);
        chk("seed.last", 32'(fwd_q[fwd_q.size() - 1]), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        $display("pkt seed: fwd=%0d drops=%0d errs=%0d", fwd_q.size(), drop_cnt, err_cnt);

        // PID bits 0-6 not counted: PID 0111_1111, data 1,1,1,1,1,0.
        send(8'h7F, 32'b011111, 6, 0);
        chk("pidrun.drops", 32'(drop_cnt), 32'd0);
        chk("pidrun.fwd", 32'(fwd_q.size()), 32'd14);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        $display("pkt pidrun: fwd=%0d drops=%0d errs=%0d", fwd_q.size(), drop_cnt, err_cnt);

        // Gapped strobe with three idle cycles between bits.
        send(8'h01, 32'b10111111, 8, 3);
        chk("gap.fwd_n", 32'(fwd_q.size()), 32'd15);
        chk("gap.fwd_seq", fwd_vec(), 32'b111_1111_0000_0001);
        chk("gap.drops", 32'(drop_cnt), 32'd1);
        chk("gap.errs", 32'(err_cnt), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        $display("pkt gapped: fwd=%0d drops=%0d errs=%0d", fwd_q.size(), drop_cnt, err_cnt);

        // EOP while a stuff bit is pending; the coincident 1 is discarded.
        send(8'h01, 32'h3F, 6, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk("eop_strip.errs", 32'(err_cnt), 32'd0);
        chk("eop_strip.active", 32'(rx_active), 32'd0);
        $display("pkt eop_strip: fwd=%0d drops=%0d errs=%0d", fwd_q.size(), drop_cnt, err_cnt);

        // Reset mid-DATA clears outputs without waiting for a clock edge.
        send(8'h01, 32'h0F, 4, 0);
        #3;
        reset_n = 1'b0;
        rx_start = 0; in_valid = 0; in_bit = 0; rx_eop = 0;
        #1;
        chk("arst.out_bit", 32'(out_bit), 32'd0);
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.active", 32'(rx_active), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        send(8'h03, 32'h5, 3, 0);
        chk("arst.restart_fwd", 32'(fwd_q.size()), 32'd11);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        $display("pkt after_reset: fwd=%0d drops=%0d errs=%0d", fwd_q.size(), drop_cnt, err_cnt);

        // Random packets biased towards long runs of ones, random gaps and EOP points.
        for (int p = 0; p < 60; p++) begin
            logic [31:0] d;
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < 32; i++) d[i] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            send(8'($urandom), d, n, -1);
            if ($urandom_range(0, 2) == 0) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            $display("pkt rand %0d: n=%0d fwd=%0d drops=%0d errs=%0d",
                     p, n, fwd_q.size(), drop_cnt, err_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_unstuffer.md
# bit_unstuffer

Receive-side USB bit unstuffer. Sits between the NRZI decoder and the receive CRC checker / PID decoder, and works on one decoded bit per `in_valid` strobe. It strips the stuffed 0 that the transmitter inserts after six consecutive 1s. It flags a stuffing error when a seventh consecutive 1 arrives. Counting rules match the transmit stuffer exactly: PID bits 0–6 are never counted, and PID bit 7 seeds the run.

## Interface
Parameters:
- `PID_BITS`, default 8: number of leading PID bits. Only the last of them is counted.
- `MAX_ONES`, default 6: run length of 1s after which a stuff bit is expected.

Ports:
- `clock`  input  1  system clock.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `rx_start`  input  1  marks the first PID bit. Qualified by `in_valid`.
- `in_valid`  input  1  `in_bit` is valid this cycle. The strobe may be continuous or gapped.
- `in_bit`  input  1  decoded (post-NRZI) bit.
- `rx_eop`  input  1  end-of-packet pulse from the line receiver.
- `out_bit`  output  1  unstuffed bit.
- `out_valid`  output  1  `out_bit` is valid. One-cycle pulse per forwarded bit.
- `drop_pulse`  output  1  one-cycle pulse when a stuff bit is discarded.
- `stuff_err`  output  1  one-cycle pulse on a seventh consecutive 1.
- `rx_active`  output  1  high while in any state other than IDLE.

## Operation
- Internal registers:
  - `bit_cnt`: PID bit index, 0 .. `PID_BITS`-1.
  - `ones_cnt`: current run of 1s, 0 .. `MAX_ONES`.
  - Both are cleared on reset and on entry to IDLE.
- State IDLE:
  - Waits for `rx_start & in_valid`.
  - On that cycle the bit is forwarded, `bit_cnt` becomes 1 and `ones_cnt` becomes 0. Next state is PID.
  - `in_valid` without `rx_start` is ignored.
- State PID:
  - Every valid bit is forwarded and `bit_cnt` increments.
  - On the bit where `bit_cnt == PID_BITS-1`: `ones_cnt` becomes `in_bit` (1 or 0). Next state is DATA.
- State DATA:
  - Every valid bit is forwarded.
  - `in_bit = 0`: `ones_cnt` is cleared.
  - `in_bit = 1` with `ones_cnt+1 < MAX_ONES`: `ones_cnt` increments.
  - `in_bit = 1` with `ones_cnt+1 == MAX_ONES`: `ones_cnt` is cleared. Next state is STRIP.
- State STRIP: acts on the next valid bit.
  - `in_bit = 0`: the bit is not forwarded. `drop_pulse` fires. Next state is DATA.
  - `in_bit = 1`: the bit is not forwarded. `stuff_err` fires. Next state is ERROR.
- State ERROR:
  - No `out_valid` output.
  - Waits for `rx_eop`.
  - `rx_start` is ignored.
- `rx_eop` in any state:
  - Next state is IDLE and both counters are cleared.
  - `rx_eop` has priority over any coincident `in_valid`. That bit is discarded.
  - A pending stuff bit (in STRIP at EOP) is not an error.
- `rx_start` outside IDLE is ignored.
- Cycles with `in_valid = 0` hold all state and counters.

## Timing
- Reset values: `out_bit = 0`, `out_valid = 0`, `drop_pulse = 0`, `stuff_err = 0`, `rx_active = 0`, state IDLE.
- All outputs are registered. Latency from the `in_valid` sample to `out_valid`, `drop_pulse` or `stuff_err` is exactly 1 cycle.
- `out_bit` holds its last value when `out_valid = 0`.
- `out_valid`, `drop_pulse` and `stuff_err` are mutually exclusive in any cycle.
- `rx_active` rises the cycle after the accepted `rx_start` and falls the cycle after `rx_eop`.
- A reset asserted mid-packet returns the block to IDLE immediately. No pulses are generated.
- Sustained throughput is one bit per clock when `in_valid` is held high.

## Test plan
- Stuff bit removed in data:
  - Stimulus: PID `8'b0000_0001` (LSB first, bit 7 = 0), then data `1,1,1,1,1,1,0,1`.
  - Required: 8 PID bits plus `1,1,1,1,1,1,1` forwarded. One `drop_pulse`, on the cycle after the 0 is sampled. No `stuff_err`.
- PID bit 7 seeds the run:
  - Stimulus: PID with bit 7 = 1, then data `1,1,1,1,1,0,0`.
  - Required: the first data 0 is dropped (six 1s counted including PID bit 7). The second 0 is forwarded.
- PID bits 0–6 not counted:
  - Stimulus: PID `8'b0111_1111`, then data `1,1,1,1,1,0`.
  - Required: all 14 bits forwarded. No `drop_pulse`.
- Stuff error:
  - Stimulus: after the PID, seven consecutive 1s, then `0,1`, then `rx_eop`.
  - Required: six bits forwarded. `stuff_err` fires once, on the cycle after the 7th 1. No `out_valid` until EOP. `rx_active` falls after EOP.
- Gapped strobe:
  - Stimulus: the stuffing pattern from scenario 1 with 3 idle cycles between bits.
  - Required: identical forwarded sequence and `drop_pulse` to scenario 1.
- EOP and reset boundaries:
  - Stimulus A: `rx_eop` while in STRIP.
  - Required A: IDLE next cycle, no `stuff_err`.
  - Stimulus B: `reset_n` low mid-DATA.
  - Required B: all outputs 0 immediately. A new `rx_start` afterwards is accepted normally.
